// File: rtl/argmin_pipe_if.sv
// Handshake bundle for argmin_pipe.
// The in_* group carries samples into the block; the out_* group carries results out.
interface argmin_pipe_if #(
  parameter int N     = 8,
  parameter int W     = 10,
  parameter int IDX_W = $clog2(N)
);
  logic             in_valid;
  logic             in_ready;
  logic [N*W-1:0]   in_bus;
  logic [N-1:0]     in_mask;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [W-1:0]     out_val;
  logic             out_none;

  modport slave (
    input  in_valid, in_bus, in_mask, mode, out_ready,
    output in_ready, out_valid, out_idx, out_val, out_none
  );

  modport master (
    output in_valid, in_bus, in_mask, mode, out_ready,
    input  in_ready, out_valid, out_idx, out_val, out_none
  );
endinterface

// File: rtl/argmin_pipe.sv
// Pipelined arg-min/arg-max over N masked unsigned channels.
// The block uses a registered binary comparator tree and one global stall enable.
module argmin_pipe #(
  parameter int N     = 8,
  parameter int W     = 10,
  parameter int IDX_W = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  argmin_pipe_if.slave  bus
);
  localparam int L = IDX_W;
  localparam int P = 1 << IDX_W;

  // Left child wins ties and also wins whenever the right child is absent.
  function automatic logic f_left_wins(
    input logic         lv,
    input logic         rv,
    input logic [W-1:0] la,
    input logic [W-1:0] ra,
    input logic         mx
  );
    logic win;
    if (!rv)      win = 1'b1;
    else if (!lv) win = 1'b0;
    else if (mx)  win = (la >= ra);
    else          win = (la <= ra);
    return win;
  endfunction

  logic             w_en;
  logic [L:0]       r_svld;
  logic             r_mode [0:L-1];
  logic [N-1:0]     r_lnv;
  logic [W-1:0]     r_lval [0:N-1];

  // Heap-ordered tree view: node i has children 2i and 2i+1; leaves sit at P..2P-1.
  logic             w_nv  [1:2*P-1];
  logic [IDX_W-1:0] w_idx [1:2*P-1];
  logic [W-1:0]     w_val [1:2*P-1];

  logic             r_out_valid;
  logic             r_out_none;
  logic [IDX_W-1:0] r_out_idx;
  logic [W-1:0]     r_out_val;

  assign w_en          = !r_out_valid || bus.out_ready;
  assign bus.in_ready  = w_en;
  assign bus.out_valid = r_out_valid;
  assign bus.out_none  = r_out_none;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_val   = r_out_val;

  // Stage valid bits and output register; result fields are only rewritten by a real sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_svld      <= '0;
      r_out_valid <= 1'b0;
      r_out_none  <= 1'b0;
      r_out_idx   <= '0;
      r_out_val   <= '0;
    end else if (w_en) begin
      r_svld      <= {r_svld[L-1:0], bus.in_valid};
      r_out_valid <= r_svld[L];
      if (r_svld[L]) begin
        r_out_none <= !w_nv[1];
        r_out_idx  <= w_nv[1] ? w_idx[1] : '0;
        r_out_val  <= w_nv[1] ? w_val[1] : '0;
      end
    end
  end

  // Stage 0: capture sample, mask and mode; mode then rides alongside each tree level.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_lnv     <= bus.in_mask;
      r_mode[0] <= bus.mode;
      for (int k = 0; k < N; k++) begin
        r_lval[k] <= bus.in_bus[k*W +: W];
      end
      for (int l = 1; l < L; l++) begin
        r_mode[l] <= r_mode[l-1];
      end
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_leaf
    assign w_idx[P+k] = IDX_W'(k);
    if (k < N) begin : g_real
      assign w_nv[P+k]  = r_lnv[k];
      assign w_val[P+k] = r_lval[k];
    end else begin : g_pad
      assign w_nv[P+k]  = 1'b0;
      assign w_val[P+k] = '0;
    end
  end

  // Tree levels 1..L: each node registers the winner of its two children from the level below.
  for (genvar i = 1; i < P; i++) begin : g_node
    localparam int CL = L - ($clog2(i + 1) - 1) - 1;

    logic             w_lw;
    logic             r_nv;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_val;

    assign w_lw = f_left_wins(w_nv[2*i], w_nv[2*i+1], w_val[2*i], w_val[2*i+1], r_mode[CL]);

    always_ff @(posedge clk) begin
      if (w_en) begin
        r_nv  <= w_nv[2*i] | w_nv[2*i+1];
        r_idx <= w_lw ? w_idx[2*i] : w_idx[2*i+1];
        r_val <= w_lw ? w_val[2*i] : w_val[2*i+1];
      end
    end

    assign w_nv[i]  = r_nv;
    assign w_idx[i] = r_idx;
    assign w_val[i] = r_val;
  end

endmodule

// File: tb/tb_argmin_pipe.sv
// Bench for argmin_pipe: directed cases plus randomized streams on an N=8 and an N=5 instance.
// A plain argmin/argmax reference model and a result queue supply the expected values.
module tb_argmin_pipe;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  argmin_pipe_if #(.N(8), .W(10)) if8 ();
  argmin_pipe_if #(.N(5), .W(10)) if5 ();

  argmin_pipe #(.N(8), .W(10)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  argmin_pipe #(.N(5), .W(10)) dut5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  int       q_i[$];
  int       q_v[$];
  int       q_n[$];
  int       sv[6][8];
  int       tv[8];
  logic [7:0] m;
  logic     md;
  int       sent, got, stall, stale;
  bit       seen_first, stalled;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: scan enabled channels in order; a strictly better value replaces the best so far.
  function automatic void ref_model(input int n, input int v[8], input logic [7:0] mk, input logic mx,
                                    output int idx, output int val, output int none);
    int b = -1;
    for (int k = 0; k < n; k++) begin
      if (mk[k]) begin
        if (b < 0) b = k;
        else if (mx && v[k] > v[b]) b = k;
        else if (!mx && v[k] < v[b]) b = k;
      end
    end
    none = (b < 0) ? 1 : 0;
    idx  = (b < 0) ? 0 : b;
    val  = (b < 0) ? 0 : v[b];
  endfunction

  function automatic logic [31:0] g_ov(input int d);
    return (d == 0) ? 32'(if8.out_valid) : 32'(if5.out_valid);
  endfunction
  function automatic logic [31:0] g_idx(input int d);
    return (d == 0) ? 32'(if8.out_idx) : 32'(if5.out_idx);
  endfunction
  function automatic logic [31:0] g_val(input int d);
    return (d == 0) ? 32'(if8.out_val) : 32'(if5.out_val);
  endfunction
  function automatic logic [31:0] g_none(input int d);
    return (d == 0) ? 32'(if8.out_none) : 32'(if5.out_none);
  endfunction
  function automatic logic [31:0] g_rdy(input int d);
    return (d == 0) ? 32'(if8.in_ready) : 32'(if5.in_ready);
  endfunction

  task automatic set_ordy(input int d, input logic r);
    if (d == 0) if8.out_ready = r;
    else        if5.out_ready = r;
  endtask

  task automatic drive(input int d, input logic vld, input int v[8], input logic [7:0] mk, input logic mx);
    if (d == 0) begin
      if8.in_valid = vld;
      for (int k = 0; k < 8; k++) if8.in_bus[k*10 +: 10] = 10'(v[k]);
      if8.in_mask = mk;
      if8.mode    = mx;
    end else begin
      if5.in_valid = vld;
      for (int k = 0; k < 5; k++) if5.in_bus[k*10 +: 10] = 10'(v[k]);
      if5.in_mask = mk[4:0];
      if5.mode    = mx;
    end
  endtask

  function automatic int rand_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 7));
      1:       return ($urandom_range(0, 1) != 0) ? 1023 : 0;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic rand_sample(output int v[8], output logic [7:0] mk, output logic mx);
    for (int k = 0; k < 8; k++) v[k] = rand_val();
    mk = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
    mx = 1'($urandom_range(0, 1));
  endtask

  task automatic push_model(input int d, input int v[8], input logic [7:0] mk, input logic mx);
    int ei, ev, en;
    ref_model((d == 0) ? 8 : 5, v, mk, mx, ei, ev, en);
    q_i.push_back(ei);
    q_v.push_back(ev);
    q_n.push_back(en);
  endtask

  // One isolated sample: checks acceptance, 4-cycle latency, result fields and single delivery.
  task automatic run_one(input int d, input int v[8], input logic [7:0] mk, input logic mx, input string tag);
    int ei, ev, en, c;
    bit seen;
    ref_model((d == 0) ? 8 : 5, v, mk, mx, ei, ev, en);
    @(negedge clk);
    drive(d, 1'b1, v, mk, mx);
    #1;
    chk({tag, "_in_ready"}, g_rdy(d), 1);
    @(negedge clk);
    drive(d, 1'b0, v, mk, mx);
    c = 0;
    seen = 0;
    while (!seen && c < 12) begin
      if (g_ov(d) == 1) seen = 1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    chk({tag, "_latency"}, seen ? c : -1, 4);
    chk({tag, "_idx"}, g_idx(d), ei);
    chk({tag, "_val"}, g_val(d), ev);
    chk({tag, "_none"}, g_none(d), en);
    @(negedge clk);
    chk({tag, "_single"}, g_ov(d), 0);
  endtask

  // Random valid/ready traffic; every delivered result is matched against the queue head.
  task automatic rand_stream(input int d, input int ncyc);
    int v[8];
    logic [7:0] mk;
    logic mx, ordy;
    q_i.delete(); q_v.delete(); q_n.delete();
    for (int k = 0; k < 8; k++) v[k] = 0;
    mk = 8'h00;
    mx = 1'b0;
    for (int c = 0; c < ncyc + 60; c++) begin
      @(negedge clk);
      ordy = (c >= ncyc) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      set_ordy(d, ordy);
      #1;
      chk("rs_in_ready", g_rdy(d), (g_ov(d) == 0 || ordy) ? 1 : 0);
      if (g_ov(d) == 1 && ordy) begin
        chk("rs_have_expected", (q_i.size() > 0) ? 1 : 0, 1);
        if (q_i.size() > 0) begin
          chk("rs_idx", g_idx(d), q_i.pop_front());
          chk("rs_val", g_val(d), q_v.pop_front());
          chk("rs_none", g_none(d), q_n.pop_front());
        end
      end
      if (c < ncyc && $urandom_range(0, 9) < 7) begin
        rand_sample(v, mk, mx);
        drive(d, 1'b1, v, mk, mx);
        if (g_rdy(d) == 1) push_model(d, v, mk, mx);
      end else begin
        drive(d, 1'b0, v, mk, mx);
      end
      if (c >= ncyc && q_i.size() == 0) break;
    end
    drive(d, 1'b0, v, mk, mx);
    set_ordy(d, 1'b1);
    chk("rs_drained", q_i.size(), 0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) tv[k] = 0;
    rst_n = 1'b1;
    if8.out_ready = 1'b1;
    if5.out_ready = 1'b1;
    drive(0, 1'b0, tv, 8'h00, 1'b0);
    drive(1, 1'b0, tv, 8'h00, 1'b0);
    #1 rst_n = 1'b0;
    #12;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", g_ov(d), 0);
      chk("rst_out_idx", g_idx(d), 0);
      chk("rst_out_val", g_val(d), 0);
      chk("rst_out_none", g_none(d), 0);
      chk("rst_in_ready", g_rdy(d), 1);
    end
    @(negedge clk);
    rst_n = 1'b1;

    tv = '{5, 3, 9, 3, 7, 8, 6, 4};
    run_one(0, tv, 8'hFF, 1'b0, "amin_tie");
    run_one(0, tv, 8'hFF, 1'b1, "amax");
    run_one(0, tv, 8'hFB, 1'b1, "amax_mask");
    run_one(0, tv, 8'hFD, 1'b0, "amin_mask");
    run_one(0, tv, 8'h00, 1'b0, "all_masked");
    tv = '{1023, 1023, 1023, 1023, 1023, 1023, 1023, 1023};
    run_one(0, tv, 8'h90, 1'b0, "all_ones");

    tv = '{7, 7, 2, 9, 2, 0, 0, 0};
    run_one(1, tv, 8'h1F, 1'b0, "n5_min");
    run_one(1, tv, 8'h1F, 1'b1, "n5_max");
    run_one(1, tv, 8'hE0, 1'b0, "n5_pad_none");
    tv = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_one(1, tv, 8'h10, 1'b1, "n5_last_only");

    // Six back-to-back samples whose unique minimum sits at channel s, with a 3-cycle stall.
    for (int s = 0; s < 6; s++)
      for (int k = 0; k < 8; k++)
        sv[s][k] = (k == s) ? int'($urandom_range(0, 99)) : int'($urandom_range(100, 1023));
    q_i.delete(); q_v.delete(); q_n.delete();
    sent = 0; got = 0; stall = 0; seen_first = 0;
    if8.out_ready = 1'b1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      @(negedge clk);
      stalled = 0;
      if (if8.out_valid && !seen_first) begin
        seen_first = 1;
        stall = 3;
      end
      if (stall > 0) begin
        stalled = 1;
        stall--;
      end
      if8.out_ready = !stalled;
      #1;
      if (stalled) begin
        chk("st_hold_valid", if8.out_valid, 1);
        chk("st_hold_idx", if8.out_idx, q_i[0]);
        chk("st_hold_val", if8.out_val, q_v[0]);
      end
      chk("st_in_ready", if8.in_ready, stalled ? 0 : 1);
      if (if8.out_valid && !stalled) begin
        chk("st_order", if8.out_idx, got);
        chk("st_idx", if8.out_idx, q_i.pop_front());
        chk("st_val", if8.out_val, q_v.pop_front());
        chk("st_none", if8.out_none, q_n.pop_front());
        got++;
      end
      if (sent < 6) begin
        tv = sv[sent];
        drive(0, 1'b1, tv, 8'hFF, 1'b0);
        if (if8.in_ready) begin
          push_model(0, tv, 8'hFF, 1'b0);
          sent++;
        end
      end else begin
        drive(0, 1'b0, tv, 8'hFF, 1'b0);
      end
    end
    drive(0, 1'b0, tv, 8'hFF, 1'b0);
    chk("st_count", got, 6);
    repeat (3) @(negedge clk);
    chk("st_no_dup", if8.out_valid, 0);

    // Asynchronous reset with one result held at the output and three more in flight.
    if8.out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      rand_sample(tv, m, md);
      drive(0, 1'b1, tv, 8'hFF, md);
    end
    @(negedge clk);
    drive(0, 1'b0, tv, 8'hFF, 1'b0);
    @(negedge clk);
    chk("mr_pre_valid", if8.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", if8.out_valid, 0);
    chk("mr_out_idx", if8.out_idx, 0);
    chk("mr_out_val", if8.out_val, 0);
    chk("mr_out_none", if8.out_none, 0);
    chk("mr_in_ready", if8.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    if8.out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (if8.out_valid) stale++;
    end
    chk("mr_no_stale", stale, 0);
    tv = '{5, 3, 9, 3, 7, 8, 6, 4};
    run_one(0, tv, 8'hFF, 1'b1, "mr_after");

    for (int r = 0; r < 12; r++) begin
      rand_sample(tv, m, md);
      run_one(r % 2, tv, m, md, "rnd_one");
    end
    rand_stream(0, 250);
    rand_stream(1, 250);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
